// File: rtl/fpadd_stream.sv
// Elastic three-stage floating-point add/subtract with IEEE specials, RNE rounding,
// per-result exception flags and a sideband tag. Subnormal inputs are flushed to zero.
module fpadd_stream #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW  = MAN_W + 4;
  localparam int LZW = $clog2(SW + 1);
  localparam int XW  = 2 * MAN_W + 6;

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv, s3_adv;

  assign s3_adv   = !out_valid | out_ready;
  assign s2_adv   = !s2_valid | s3_adv;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: classify, pick the larger magnitude, align the smaller one
  logic             a_s, b_es, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge;
  logic [EXP_W-1:0] a_e, b_e, l_e, s_e, e_diff, sh_amt;
  logic [MAN_W-1:0] a_m, b_m, l_m, s_m;
  logic             l_s, s_s;
  logic [XW-1:0]    ext_s, shifted;
  logic [SW-1:0]    large_al, small_al;
  logic             spec_c;
  logic [W-1:0]     spec_res_c;
  logic [3:0]       spec_flags_c;

  always_comb begin
    a_s    = in_a[W-1];
    b_es   = in_b[W-1] ^ in_sub;
    a_e    = in_a[W-2:MAN_W];
    b_e    = in_b[W-2:MAN_W];
    a_m    = in_a[MAN_W-1:0];
    b_m    = in_b[MAN_W-1:0];
    a_zero = (a_e == '0);
    b_zero = (b_e == '0);
    a_inf  = (a_e == '1) && (a_m == '0);
    b_inf  = (b_e == '1) && (b_m == '0);
    a_nan  = (a_e == '1) && (a_m != '0);
    b_nan  = (b_e == '1) && (b_m != '0);
    a_ge   = (in_a[W-2:0] >= in_b[W-2:0]);

    l_e = a_ge ? a_e : b_e;
    l_m = a_ge ? a_m : b_m;
    l_s = a_ge ? a_s : b_es;
    s_e = a_ge ? b_e : a_e;
    s_m = a_ge ? b_m : a_m;
    s_s = a_ge ? b_es : a_s;

    e_diff = l_e - s_e;
    if (e_diff > EXP_W'(MAN_W + 3)) sh_amt = EXP_W'(MAN_W + 3);
    else                            sh_amt = e_diff;

    // Bits shifted below the round position collapse into sticky
    ext_s    = {1'b1, s_m, {(MAN_W + 5){1'b0}}};
    shifted  = ext_s >> sh_amt;
    small_al = {shifted[XW-1 -: MAN_W+3], |shifted[MAN_W+2:0]};
    large_al = {1'b1, l_m, 3'b000};

    spec_c       = 1'b1;
    spec_res_c   = '0;
    spec_flags_c = 4'b0000;
    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_es))) begin
      spec_res_c   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_flags_c = 4'b1000;
    end else if (a_inf) begin
      spec_res_c = {a_s, in_a[W-2:0]};
    end else if (b_inf) begin
      spec_res_c = {b_es, in_b[W-2:0]};
    end else if (a_zero && b_zero) begin
      spec_res_c = {a_s & b_es, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spec_res_c = {b_es, in_b[W-2:0]};
    end else if (b_zero) begin
      spec_res_c = in_a;
    end else begin
      spec_c = 1'b0;
    end
  end

  logic             s1_spec, s1_sign, s1_subop;
  logic [W-1:0]     s1_spec_res;
  logic [3:0]       s1_spec_flags;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0]    s1_large, s1_small;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid      <= in_valid;
      s1_spec       <= spec_c;
      s1_spec_res   <= spec_res_c;
      s1_spec_flags <= spec_flags_c;
      s1_sign       <= l_s;
      s1_subop      <= (l_s != s_s);
      s1_exp        <= l_e;
      s1_large      <= large_al;
      s1_small      <= small_al;
      s1_tag        <= in_tag;
    end
  end

  // Stage 2: magnitude add or subtract; the larger operand keeps the result non-negative
  logic             s2_spec, s2_sign;
  logic [W-1:0]     s2_spec_res;
  logic [3:0]       s2_spec_flags;
  logic [EXP_W-1:0] s2_exp;
  logic [SW:0]      s2_sum;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid      <= s1_valid;
      s2_spec       <= s1_spec;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;
      s2_sign       <= s1_sign;
      s2_exp        <= s1_exp;
      s2_sum        <= s1_subop ? ({1'b0, s1_large} - {1'b0, s1_small})
                                : ({1'b0, s1_large} + {1'b0, s1_small});
      s2_tag        <= s1_tag;
    end
  end

  // Stage 3: normalise, round to nearest even, detect range exceptions, pack
  logic [LZW-1:0]          lz;
  logic [SW-1:0]           norm;
  logic signed [EXP_W+1:0] e_norm, e_fin;
  logic                    round_up, inexact;
  logic [MAN_W+1:0]        rnd;
  logic [MAN_W-1:0]        mant;
  logic [W-1:0]            res_c;
  logic [3:0]              flags_c;

  always_comb begin
    lz = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (s2_sum[i]) lz = LZW'(SW - 1 - i);
    end

    if (s2_sum[SW]) begin
      norm   = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
      e_norm = $signed({2'b00, s2_exp}) + 1;
    end else begin
      norm   = s2_sum[SW-1:0] << lz;
      e_norm = $signed({2'b00, s2_exp}) - $signed({{(EXP_W+2-LZW){1'b0}}, lz});
    end

    inexact  = |norm[2:0];
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    mant     = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    e_fin    = e_norm + $signed({{(EXP_W+1){1'b0}}, rnd[MAN_W+1]});

    res_c   = {s2_sign, e_fin[EXP_W-1:0], mant};
    flags_c = {3'b000, inexact};
    if (s2_spec) begin
      res_c   = s2_spec_res;
      flags_c = s2_spec_flags;
    end else if (s2_sum == '0) begin
      res_c   = '0;
      flags_c = 4'b0000;
    end else if (e_fin >= $signed({2'b00, {EXP_W{1'b1}}})) begin
      res_c   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c = 4'b0101;
    end else if (e_fin <= 0) begin
      res_c   = {s2_sign, {(W-1){1'b0}}};
      flags_c = 4'b0011;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= 4'b0000;
      out_tag    <= '0;
    end else if (s3_adv) begin
      out_valid  <= s2_valid;
      out_result <= res_c;
      out_flags  <= flags_c;
      out_tag    <= s2_tag;
    end
  end

endmodule
